// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle 24-bit CPU control unit: opcodes, mux
// selects, FSM states and the per-state control-strobe decode.
package cpu_pkg;

  localparam int OP_R    = 0;
  localparam int OP_ADDI = 1;
  localparam int OP_LW   = 2;
  localparam int OP_SW   = 3;
  localparam int OP_BEQ  = 4;
  localparam int OP_JMP  = 5;
  localparam int OP_HALT = 15;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_INC  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, R_EXEC, R_WB, I_EXEC, I_WB, MEM_ADDR,
    MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, HALT, TRAP
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // FETCH reports ir_write/pc_write as 1; the top gates them with MemReady.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_INC;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
      end
      DECODE: c.alu_src_b = SRCB_BOFF;
      R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      I_EXEC, MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      I_WB: c.reg_write = 1'b1;
      MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_wait_state(input state_e s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; expired flags the configured limit.
// TIMEOUT of 0 never expires.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  // Saturates at the limit so a long stall can never wrap back below it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && (cnt_q != TW'(TIMEOUT))) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT > 0) && (cnt_q == TW'(TIMEOUT));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 24-bit CPU: sequences fetch/decode/execute/
// memory/writeback, drives datapath strobes and counts retired instructions.
module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic                Halted,
  output logic                Trap,
  output logic [CNT_W-1:0]    Retired,
  output state_e              dbg_state
);

  // Handshake: a memory access strobe (MemRead/MemWrite) is held while the
  // FSM waits; MemReady high in a cycle means that access completes at the
  // following edge, and the FSM advances.

  state_e             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               halted_q, halted_d;
  logic               trap_q, trap_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               is_store_q, is_store_d;
  logic               retire;
  logic               tmr_clear, tmr_count, tmr_expired;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .clear   (tmr_clear),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    retire     = 1'b0;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (MemReady)         state_d = DECODE;
        else if (tmr_expired) state_d = TRAP;
      end
      DECODE: begin
        // Latch LW/SW choice so MEM_ADDR does not rely on Opcode staying put.
        is_store_d = (int'(Opcode) == OP_SW);
        case (int'(Opcode))
          OP_R:         state_d = R_EXEC;
          OP_ADDI:      state_d = I_EXEC;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_JMP:       state_d = JUMP;
          OP_HALT:      state_d = HALT;
          default:      state_d = TRAP;
        endcase
      end
      R_EXEC:   state_d = R_WB;
      I_EXEC:   state_d = I_WB;
      MEM_ADDR: state_d = is_store_q ? MEM_WRITE : MEM_READ;
      MEM_READ: begin
        if (MemReady)         state_d = MEM_WB;
        else if (tmr_expired) state_d = TRAP;
      end
      MEM_WRITE: begin
        if (MemReady) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else if (tmr_expired) begin
          state_d = TRAP;
        end
      end
      R_WB, I_WB, MEM_WB, BRANCH, JUMP: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:    state_d = HALT;
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase

    halted_d  = halted_q | (state_d == HALT);
    trap_d    = trap_q | (state_d == TRAP);
    retired_d = retired_q + (retire ? CNT_W'(1) : CNT_W'(0));
    ctrl_d    = decode_ctrl(state_d);
  end

  assign tmr_clear = is_wait_state(state_d) && (state_d != state_q);
  assign tmr_count = is_wait_state(state_q) && !MemReady;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      halted_q   <= 1'b0;
      trap_q     <= 1'b0;
      retired_q  <= '0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      halted_q   <= halted_d;
      trap_q     <= trap_d;
      retired_q  <= retired_d;
      is_store_q <= is_store_d;
    end
  end

  // IR load and PC increment in FETCH happen only when the read returns.
  logic fetch_gate;
  assign fetch_gate = (state_q == FETCH) ? MemReady : 1'b1;

  assign PCWrite     = ctrl_q.pc_write & fetch_gate;
  assign IRWrite     = ctrl_q.ir_write & fetch_gate;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign IorD        = ctrl_q.i_or_d;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign MemToReg    = ctrl_q.mem_to_reg;
  assign RegDst      = ctrl_q.reg_dst;
  assign RegWrite    = ctrl_q.reg_write;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign PCSource    = ctrl_q.pc_source;
  assign Halted      = halted_q;
  assign Trap        = trap_q;
  assign Retired     = retired_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation control unit for the 24-bit CPU, replacing the single-cycle combinational decoder with a multi-cycle FSM.
- Sequences fetch, decode, execute, memory and writeback over several clocks and drives the multi-cycle datapath's control strobes.
- Waits on a memory-ready handshake, with a timeout, and counts retired instructions.
- Widths and timeout are parametrised.

Parameters:
OPCODE_W, 4, opcode field width
CNT_W, 16, retired-instruction counter width
TIMEOUT, 15, max memory wait cycles before trap; 0 disables timeout

Ports:
Clock  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Opcode  input  OPCODE_W  opcode from instruction register
MemReady  input  1  memory completes current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU zero
IorD  output  1  0 = address from PC, 1 = address from ALU out
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
MemToReg  output  1  writeback from memory data
RegDst  output  1  1 = rd, 0 = rt destination
RegWrite  output  1  register file write
ALUSrcA  output  1  0 = PC, 1 = reg A
ALUSrcB  output  2  00 = reg B, 01 = increment, 10 = immediate, 11 = branch offset
ALUOp  output  2  00 = add, 01 = sub, 10 = funct
PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
Halted  output  1  sticky; HALT executed
Trap  output  1  sticky; illegal opcode or memory timeout
Retired  output  CNT_W  retired-instruction count

Behaviour:
- Opcodes: 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 JMP, 15 HALT. All others are illegal.
- Reset_n low, asynchronous:
  - state = IDLE, Retired = 0, wait timer = 0.
  - Halted = Trap = 0.
  - All strobes 0.
- After reset release: IDLE -> FETCH on the next edge.
- Outputs are Moore, decoded from state. Exception: IRWrite and PCWrite in FETCH are gated by MemReady.
- Signals not listed for a state are 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Stay in FETCH until MemReady, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - R -> R_EXEC
  - ADDI -> I_EXEC
  - LW/SW -> MEM_ADDR
  - BEQ -> BRANCH
  - JMP -> JUMP
  - HALT -> HALT
  - illegal -> TRAP
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_WB.
- R_WB: RegWrite=1, RegDst=1 -> FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> I_WB.
- I_WB: RegWrite=1, RegDst=0 -> FETCH.
- MEM_ADDR: same strobes as I_EXEC. LW -> MEM_READ, SW -> MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Wait for MemReady, then -> MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0 -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Wait for MemReady, then -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- HALT and TRAP: terminal until reset, all strobes 0.
  - Halted=1 in HALT; Trap=1 in TRAP. Both are registered and sticky.
  - A HALT is not counted in Retired.
- Latency with MemReady held 1 (cycles FETCH..last state): R 4, ADDI 4, LW 5, SW 4, BEQ 3, JMP 3.
- Retired increments by 1 on the edge leaving R_WB, I_WB, MEM_WB, MEM_WRITE (with MemReady), BRANCH or JUMP. Wraps modulo 2^CNT_W.
- Wait timer:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments on each cycle in those states with MemReady=0.
  - If TIMEOUT>0 and the timer equals TIMEOUT while MemReady=0, next state = TRAP.
  - If MemReady=1 in the same cycle, completion wins.
- Reset asserted mid-instruction aborts immediately to IDLE. No partial strobe persists.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants
  - ALUOp, ALUSrcB and PCSource encodings
  - state enum: IDLE, FETCH, DECODE, R_EXEC, R_WB, I_EXEC, I_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, HALT, TRAP
- One sub-module, mem_wait_timer (parameter TIMEOUT), with inputs clear/count and output expired.

Test Plan:
- Reset release with MemReady=1, Opcode=0: states IDLE, FETCH, DECODE, R_EXEC, R_WB, then FETCH. RegWrite=1, RegDst=1 only in R_WB. Retired=1.
- LW with MemReady low 3 cycles in MEM_READ, TIMEOUT=15: MemRead=1, IorD=1 held 4 cycles. Then MEM_WB with MemToReg=1. Retired=1.
- Opcode=7 at DECODE: next cycle Trap=1, all strobes 0. Trap stays 1 for 20 cycles until Reset_n low.
- MemReady held 0 in FETCH, TIMEOUT=15: Trap=1 after 16 wait cycles. With TIMEOUT=0, no trap after 100 cycles.
- Sequence ADDI, SW, BEQ, JMP, HALT: Retired=4 and Halted=1. BEQ asserts PCWriteCond=1, PCSource=01. JMP asserts PCWrite=1, PCSource=10.
- CNT_W=2 with five R-type instructions: Retired goes 1, 2, 3, 0, 1. Reset_n pulsed low mid-R_EXEC: outputs 0 immediately and Retired=0.
